// File: rtl/control_sequencer.sv
// Instruction register and FETCH/EXEC sequencer of the multicycle control unit.
// Holds I, state and status; gates the decoder control word onto the datapath.
module control_sequencer #(
   parameter int unsigned MAX_EXEC = 4,
   parameter int unsigned CNT_W    = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [31:0]      instr_data,
   input  logic             instr_valid,
   output logic             instr_req,
   input  logic [32:0]      cw_in,
   input  logic [4:0]       alu_status,
   output logic [31:0]      I,
   output logic [1:0]       state,
   output logic [4:0]       status,
   output logic [32:0]      cw_out,
   output logic [CNT_W-1:0] retired,
   output logic             fault
);

   localparam int unsigned IW   = 32;
   localparam int unsigned CW_W = 33;
   localparam int unsigned SF_W = 5;
   localparam int unsigned ST_W = 2;

   localparam logic [1:0] PH_IDLE  = 2'd0;
   localparam logic [1:0] PH_FETCH = 2'd1;
   localparam logic [1:0] PH_EXEC  = 2'd2;

   // Inert word: no ALU/bus drive, register selects parked at 31, no writes, PC held.
   localparam logic [CW_W-1:0] SAFE_CW = {1'b0, 1'b0, 5'b11111, 1'b0, 5'd31, 5'd31, 5'd31, 10'd0};

   localparam logic [ST_W-1:0] ECNT_LAST = ST_W'(MAX_EXEC - 1);

   logic [1:0]       r_phase,     w_phase_nxt;
   logic [IW-1:0]    r_ir,        w_ir_nxt;
   logic [ST_W-1:0]  r_state,     w_state_nxt;
   logic [ST_W-1:0]  r_ecnt,      w_ecnt_nxt;
   logic [SF_W-1:0]  r_status,    w_status_nxt;
   logic [CNT_W-1:0] r_retired,   w_retired_nxt;
   logic             r_fault,     w_fault_nxt;
   logic             r_instr_req, w_instr_req_nxt;

   // State register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_phase     <= PH_IDLE;
         r_ir        <= '0;
         r_state     <= '0;
         r_ecnt      <= '0;
         r_status    <= '0;
         r_retired   <= '0;
         r_fault     <= 1'b0;
         r_instr_req <= 1'b0;
      end else begin
         r_phase     <= w_phase_nxt;
         r_ir        <= w_ir_nxt;
         r_state     <= w_state_nxt;
         r_ecnt      <= w_ecnt_nxt;
         r_status    <= w_status_nxt;
         r_retired   <= w_retired_nxt;
         r_fault     <= w_fault_nxt;
         r_instr_req <= w_instr_req_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      w_phase_nxt   = r_phase;
      w_ir_nxt      = r_ir;
      w_state_nxt   = r_state;
      w_ecnt_nxt    = r_ecnt;
      w_status_nxt  = r_status;
      w_retired_nxt = r_retired;
      w_fault_nxt   = r_fault;

      case (r_phase)
         PH_IDLE: begin
            w_phase_nxt = PH_FETCH;
         end
         PH_FETCH: begin
            if (instr_valid) begin
               w_ir_nxt    = instr_data;
               w_state_nxt = '0;
               w_ecnt_nxt  = '0;
               w_phase_nxt = PH_EXEC;
            end
         end
         PH_EXEC: begin
            if (cw_in[2]) begin
               w_status_nxt = alu_status;
            end
            if (cw_in[1:0] == 2'b00) begin
               w_phase_nxt   = PH_FETCH;
               w_state_nxt   = '0;
               w_retired_nxt = r_retired + CNT_W'(1);
            end else if (r_ecnt == ECNT_LAST) begin
               // Runaway instruction: abandon it without counting it as retired.
               w_phase_nxt = PH_FETCH;
               w_state_nxt = '0;
               w_fault_nxt = 1'b1;
            end else begin
               w_state_nxt = cw_in[1:0];
               w_ecnt_nxt  = r_ecnt + ST_W'(1);
            end
         end
         default: begin
            w_phase_nxt = PH_IDLE;
         end
      endcase

      w_instr_req_nxt = (w_phase_nxt == PH_FETCH);
   end

   assign cw_out    = (r_phase == PH_EXEC) ? cw_in : SAFE_CW;
   assign instr_req = r_instr_req;
   assign I         = r_ir;
   assign state     = r_state;
   assign status    = r_status;
   assign retired   = r_retired;
   assign fault     = r_fault;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: stimulus queues expected output values,
// a negedge monitor drains the queue and compares against the DUT.
module tb_control_sequencer;

   localparam logic [32:0] SAFE = 33'h07DFFFC00;

   localparam int S_I    = 0;
   localparam int S_ST   = 1;
   localparam int S_STAT = 2;
   localparam int S_CW   = 3;
   localparam int S_RET  = 4;
   localparam int S_FLT  = 5;
   localparam int S_REQ  = 6;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] instr_data;
   logic        instr_valid;
   logic        instr_req;
   logic [32:0] cw_in;
   logic [4:0]  alu_status;
   logic [31:0] I;
   logic [1:0]  state;
   logic [4:0]  status;
   logic [32:0] cw_out;
   logic [31:0] retired;
   logic        fault;

   typedef struct {
      int          sig;
      logic [63:0] val;
      string       name;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   control_sequencer #(.MAX_EXEC(4), .CNT_W(32)) dut (
      .clock       (clock),
      .reset       (reset),
      .instr_data  (instr_data),
      .instr_valid (instr_valid),
      .instr_req   (instr_req),
      .cw_in       (cw_in),
      .alu_status  (alu_status),
      .I           (I),
      .state       (state),
      .status      (status),
      .cw_out      (cw_out),
      .retired     (retired),
      .fault       (fault)
   );

   always #5 clock = ~clock;

   function automatic logic [63:0] actual(input int sig);
      case (sig)
         S_I:     return 64'(I);
         S_ST:    return 64'(state);
         S_STAT:  return 64'(status);
         S_CW:    return 64'(cw_out);
         S_RET:   return 64'(retired);
         S_FLT:   return 64'(fault);
         S_REQ:   return 64'(instr_req);
         default: return 64'hDEAD;
      endcase
   endfunction

   // Monitor: compare every queued expectation at the falling edge.
   always @(negedge clock) begin
      while (sb_q.size() > 0) begin
         exp_t        e;
         logic [63:0] a;
         e = sb_q.pop_front();
         a = actual(e.sig);
         n_checks++;
         if (a !== e.val) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", e.name, a, e.val);
         end
      end
   end

   task automatic push(input int sig, input logic [63:0] val, input string name);
      exp_t e;
      e.sig  = sig;
      e.val  = val;
      e.name = name;
      sb_q.push_back(e);
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic fetch(input logic [31:0] d, input string name);
      instr_valid = 1'b1;
      instr_data  = d;
      tick();
      instr_valid = 1'b0;
      push(S_I, 64'(d), name);
      push(S_REQ, 64'd0, name);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not end, checks %0d", n_checks);
      $fatal(1);
   end

   initial begin
      reset       = 1'b0;
      instr_data  = '0;
      instr_valid = 1'b0;
      cw_in       = 33'h1FFFFFFFF;
      alu_status  = 5'b11111;

      // Reset values
      repeat (3) tick();
      push(S_I, 64'd0, "rst_I");
      push(S_ST, 64'd0, "rst_state");
      push(S_STAT, 64'd0, "rst_status");
      push(S_RET, 64'd0, "rst_retired");
      push(S_FLT, 64'd0, "rst_fault");
      push(S_REQ, 64'd0, "rst_req");
      push(S_CW, 64'(SAFE), "rst_cw");

      // T1: reset release, IDLE, first fetch, single-cycle instruction
      reset = 1'b1;
      alu_status = 5'b00000;
      push(S_REQ, 64'd0, "idle_req");
      push(S_CW, 64'(SAFE), "idle_cw");
      tick();
      push(S_REQ, 64'd1, "fetch_req");
      push(S_CW, 64'(SAFE), "fetch_cw");
      cw_in = 33'h100000100;
      fetch(32'hB4000040, "t1_I");
      push(S_CW, 64'(33'h100000100), "t1_cw_pass");
      push(S_ST, 64'd0, "t1_state");
      tick();
      push(S_RET, 64'd1, "t1_retired");
      push(S_REQ, 64'd1, "t1_back_fetch");
      push(S_CW, 64'(SAFE), "t1_cw_safe");

      // T2: multi-state 01,10,00; instr_valid during EXEC ignored
      fetch(32'h11112222, "t2_I");
      push(S_ST, 64'd0, "t2_state0");
      cw_in       = 33'h080000001;
      instr_valid = 1'b1;
      instr_data  = 32'hDEADBEEF;
      tick();
      instr_valid = 1'b0;
      push(S_ST, 64'd1, "t2_state1");
      push(S_I, 64'h11112222, "t2_I_hold");
      push(S_RET, 64'd1, "t2_ret_mid1");
      cw_in = 33'h080000002;
      tick();
      push(S_ST, 64'd2, "t2_state2");
      push(S_RET, 64'd1, "t2_ret_mid2");
      cw_in = 33'h080000000;
      tick();
      push(S_ST, 64'd0, "t2_state_end");
      push(S_RET, 64'd2, "t2_retired");
      push(S_REQ, 64'd1, "t2_req");

      // T3: status load in EXEC only
      alu_status = 5'b10101;
      cw_in      = 33'h000000004;
      tick();
      push(S_STAT, 64'd0, "t3_no_load_fetch");
      fetch(32'h33330003, "t3_I");
      push(S_CW, 64'h4, "t3_cw");
      tick();
      push(S_STAT, 64'b10101, "t3_status_ld");
      push(S_RET, 64'd3, "t3_retired");
      alu_status = 5'b01010;
      tick();
      push(S_STAT, 64'b10101, "t3_status_hold");

      // T4: five wait states with toggling data, latch on the sixth
      cw_in = 33'h100000003;
      for (int k = 0; k < 5; k++) begin
         instr_data = (k % 2 == 0) ? 32'hFFFFFFFF : 32'h00000000;
         tick();
         push(S_I, 64'h33330003, "t4_I_hold");
         push(S_CW, 64'(SAFE), "t4_cw_safe");
         push(S_REQ, 64'd1, "t4_req");
      end
      fetch(32'hA5A50006, "t4_I_latch");
      cw_in = 33'h0;
      tick();
      push(S_RET, 64'd4, "t4_retired");

      // T5: guard after MAX_EXEC cycles
      fetch(32'h55550005, "t5_I");
      cw_in = 33'h000000001;
      for (int k = 0; k < 3; k++) begin
         tick();
         push(S_ST, 64'd1, "t5_state");
         push(S_FLT, 64'd0, "t5_fault_low");
         push(S_REQ, 64'd0, "t5_req_low");
      end
      tick();
      push(S_FLT, 64'd1, "t5_fault");
      push(S_ST, 64'd0, "t5_state_forced");
      push(S_REQ, 64'd1, "t5_forced_fetch");
      push(S_RET, 64'd4, "t5_ret_unchanged");
      fetch(32'h66660006, "t5_I2");
      cw_in = 33'h0;
      tick();
      push(S_RET, 64'd5, "t5_retired_next");
      push(S_FLT, 64'd1, "t5_fault_sticky");

      // T6: asynchronous reset in state 2
      fetch(32'h77770007, "t6_I");
      cw_in = 33'h000000001;
      tick();
      push(S_ST, 64'd1, "t6_state1");
      cw_in = 33'h000000002;
      tick();
      #1;
      reset = 1'b0;
      #1;
      push(S_CW, 64'(SAFE), "t6_cw_safe");
      push(S_ST, 64'd0, "t6_state_rst");
      push(S_RET, 64'd0, "t6_ret_rst");
      push(S_FLT, 64'd0, "t6_fault_rst");
      push(S_I, 64'd0, "t6_I_rst");
      tick();
      tick();
      reset = 1'b1;
      cw_in = 33'h1FFFFFFFF;
      push(S_REQ, 64'd0, "t6_idle_req");
      push(S_CW, 64'(SAFE), "t6_idle_cw");
      tick();
      push(S_REQ, 64'd1, "t6_fetch_req");
      fetch(32'h88880008, "t6_I2");
      cw_in = 33'h0;
      tick();
      push(S_RET, 64'd1, "t6_retired");

      @(negedge clock);
      #1;
      n_checks++;
      if (sb_q.size() != 0) begin
         n_errors++;
         $display("FAIL sb_drain: got %0d pending expected 0", sb_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Instruction-register and state-sequencing stage of the multicycle control unit. Sits directly upstream of the per-class instruction decoders. It fetches each instruction word from instruction memory with a request/valid handshake and holds it in the instruction register (`I`). It drives the 2-bit execution `state` into the decoders, consumes the 33-bit control word returned by the selected decoder, forwards that word to the datapath, owns the status-flag register, and sequences FETCH/EXEC phases.

## Interface
- `MAX_EXEC`, 4: maximum EXEC cycles per instruction before a forced return to FETCH (range 1–4).
- `CNT_W`, 32: width of the retired-instruction counter.

- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `instr_data`  in  32  instruction memory read data.
- `instr_valid`  in  1  `instr_data` valid this cycle; ignored unless `instr_req`=1.
- `instr_req`  out  1  fetch request to instruction memory.
- `cw_in`  in  33  control word from the selected decoder; combinational function of `I`, `state` and `status`.
- `alu_status`  in  5  live ALU flags.
- `I`  out  32  instruction register.
- `state`  out  2  current execution state presented to the decoders.
- `status`  out  5  status-flag register.
- `cw_out`  out  33  control word applied to the datapath.
- `retired`  out  CNT_W  count of completed instructions, wraps modulo 2^CNT_W.
- `fault`  out  1  sticky flag: an instruction exceeded `MAX_EXEC` cycles.

## Operation
- **Control-word layout**, MSB first:
  - alu_en[32], alu_bs[31], alu_fs[30:26], rf_b_en[25], rf_sa[24:20], rf_sb[19:15], rf_da[14:10]
  - rf_w[9], ram_en[8], ram_w[7], pc_en[6], pc_fs[5:4], pc_is[3], status_ld[2], next_state[1:0]
- **Phase register**: IDLE, FETCH, EXEC. A 2-bit `state` register and a 2-bit exec-cycle counter `ecnt` accompany it.
- **Reset** (`reset`=0, asynchronous):
  - phase=IDLE, `I`=0, `state`=0, `status`=0, `ecnt`=0, `retired`=0, `fault`=0.
  - Outputs: `instr_req`=0, `cw_out`=SAFE.
- **SAFE word**: alu_fs=5'b11111, rf_sa=rf_sb=rf_da=31, all other fields 0. No bus drivers, no writes, PC held.
- **IDLE**: `cw_out`=SAFE. Moves to FETCH on the next clock. This gives one quiet cycle after reset release.
- **FETCH**:
  - `instr_req`=1, `cw_out`=SAFE.
  - On a clock with `instr_valid`=1: `I`<=`instr_data`, `state`<=0, `ecnt`<=0, phase<=EXEC.
  - Otherwise hold.
- **EXEC**:
  - `instr_req`=0. `cw_out`=`cw_in`, passed through combinationally.
  - Each clock: if `cw_in[2]`=1, `status`<=`alu_status`.
  - If `cw_in[1:0]`=2'b00: phase<=FETCH, `state`<=0, `retired`<=`retired`+1.
  - Otherwise `state`<=`cw_in[1:0]`, `ecnt`<=`ecnt`+1.
- **Guard**: in EXEC, if `ecnt`=`MAX_EXEC`−1 and `cw_in[1:0]`≠0:
  - phase<=FETCH, `state`<=0, `fault`<=1.
  - `retired` is not incremented.
  - The status load for that cycle still applies.
- `fault` clears only on reset.
- `instr_valid` outside FETCH has no effect.
- Status is written only in EXEC. It is never written in FETCH or IDLE, regardless of `alu_status`.

## Timing
- `instr_req`, `state`, `I`, `status`, `retired` and `fault` are registered.
- `cw_out` is combinational from the phase register and `cw_in`. There is no added latency from decoder to datapath.
- Minimum fetch: 1 cycle, when `instr_valid` is high in the first FETCH cycle.
- An instruction with k EXEC cycles (k ≤ `MAX_EXEC`) occupies F+k cycles, where F is the number of FETCH cycles.
- First `instr_req`=1 appears 1 cycle after reset release, after the IDLE cycle.
- Reset asserted mid-EXEC: `cw_out` becomes SAFE in the same cycle, asynchronously. The partial instruction is not counted.
- `retired` wraps from all-ones to 0 without a flag.

## Test plan
1. **Reset then fetch.**
   - Stimulus: hold `reset`=0 for 3 cycles, release; memory returns 32'hB4000040 with `instr_valid` in the first FETCH cycle; `cw_in` next_state=00.
   - Required: `instr_req` rises 1 cycle after release; `I`=32'hB4000040 on the next edge; `cw_out`=`cw_in` for exactly 1 cycle; `retired`=1; then back to FETCH.
2. **Multi-state instruction.**
   - Stimulus: `cw_in` next_state sequence 01, 10, 00.
   - Required: `state` reads 0, 1, 2 across three EXEC cycles; `retired` increments once, at the third edge.
3. **Status load.**
   - Stimulus: in EXEC with `alu_status`=5'b10101 and status_ld=1.
   - Required: `status`=5'b10101 after the edge.
   - Stimulus: same flags in FETCH.
   - Required: `status` unchanged.
4. **Fetch wait states.**
   - Stimulus: `instr_valid` low for 5 FETCH cycles, with `instr_data` toggling.
   - Required: `I` unchanged and `cw_out`=SAFE throughout; latch occurs on the 6th cycle when valid goes high.
5. **Guard.**
   - Stimulus: `cw_in` next_state stuck at 01 with `MAX_EXEC`=4.
   - Required: forced to FETCH after 4 EXEC cycles; `fault`=1; `retired` unchanged; `fault` stays 1 until reset.
6. **Async reset mid-EXEC.**
   - Stimulus: assert `reset` between clock edges in state 2.
   - Required: `cw_out`=SAFE, `state`=0 and `retired`=0 immediately; phase is IDLE after release.
